// File: rtl/target_ctrl_if.sv
// Signal bundle between the reaction-game controller and its surroundings.
//
// Signalling protocol: there is no valid/ready back-pressure anywhere on this
// bundle. start, tick_ms and click are single-cycle strobes sampled on the
// rising clock edge; new_ball, hit and miss are single-cycle registered
// strobes. The position generator must present ball_x/ball_y on the cycle
// after new_ball, and the controller always takes it on that cycle.
// ball_visible, tgt_x/tgt_y and the counters are registered levels.
// dbg_state mirrors the controller state encoding for observation only.
interface target_ctrl_if;
   logic        start;
   logic        tick_ms;
   logic        click;
   logic [9:0]  cursor_x;
   logic [9:0]  cursor_y;
   logic [9:0]  ball_x;
   logic [9:0]  ball_y;
   logic        new_ball;
   logic        ball_visible;
   logic [9:0]  tgt_x;
   logic [9:0]  tgt_y;
   logic        hit;
   logic        miss;
   logic [7:0]  score;
   logic [7:0]  misses;
   logic [11:0] react_ms;
   logic [7:0]  round_no;
   logic        done;
   logic [2:0]  dbg_state;

   modport master (
      output start, tick_ms, click, cursor_x, cursor_y, ball_x, ball_y,
      input  new_ball, ball_visible, tgt_x, tgt_y, hit, miss, score, misses,
             react_ms, round_no, done, dbg_state
   );

   modport slave (
      input  start, tick_ms, click, cursor_x, cursor_y, ball_x, ball_y,
      output new_ball, ball_visible, tgt_x, tgt_y, hit, miss, score, misses,
             react_ms, round_no, done, dbg_state
   );
endinterface

// File: rtl/target_ctrl.sv
// Reaction-time target game controller.
// A round requests a target position, shows the target, then scores a click
// inside the box as a hit (recording the reaction time) and a click outside it
// or a timeout as a miss. A blank gap separates rounds; after the configured
// number of rounds the game parks in DONE until the next start.
module target_ctrl #(
   parameter int BALL_SIZE  = 48,
   parameter int TIMEOUT_MS = 1500,
   parameter int GAP_MS     = 500,
   parameter int ROUNDS     = 20
) (
   input  logic         clk,
   input  logic         rst,
   target_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_LOAD = 3'd2,
      S_SHOW = 3'd3,
      S_GAP  = 3'd4,
      S_DONE = 3'd5
   } state_t;

   // Parameters narrowed once so every compare below is width-matched.
   localparam logic [10:0] C_BALL    = 11'(BALL_SIZE);
   localparam logic [16:0] C_TIMEOUT = 17'(TIMEOUT_MS);
   localparam logic [16:0] C_GAP     = 17'(GAP_MS);
   localparam logic [7:0]  C_ROUNDS  = 8'(ROUNDS);

   // State and registered outputs
   state_t      r_state;
   logic [15:0] r_ms;
   logic [15:0] r_gap;
   logic        r_new_ball;
   logic        r_visible;
   logic        r_hit;
   logic        r_miss;
   logic        r_done;
   logic [7:0]  r_score;
   logic [7:0]  r_misses;
   logic [11:0] r_react;
   logic [7:0]  r_round;
   logic [9:0]  r_tgt_x;
   logic [9:0]  r_tgt_y;

   // Next-state values
   state_t      w_state_nxt;
   logic [15:0] w_ms;
   logic [15:0] w_gap;
   logic        w_new_ball;
   logic        w_visible;
   logic        w_hit;
   logic        w_miss;
   logic        w_done;
   logic [7:0]  w_score;
   logic [7:0]  w_misses;
   logic [11:0] w_react;
   logic [7:0]  w_round;
   logic [9:0]  w_tgt_x;
   logic [9:0]  w_tgt_y;

   // Hit-box test, one bit wider than the screen so tgt+BALL_SIZE never wraps.
   logic [10:0] w_cx;
   logic [10:0] w_cy;
   logic [10:0] w_tx;
   logic [10:0] w_ty;
   logic        w_in_x;
   logic        w_in_y;
   logic        w_in_box;

   // Round events
   logic        w_ms_last;
   logic        w_gap_last;
   logic [11:0] w_ms_sat;

   assign w_cx     = {1'b0, bus.cursor_x};
   assign w_cy     = {1'b0, bus.cursor_y};
   assign w_tx     = {1'b0, r_tgt_x};
   assign w_ty     = {1'b0, r_tgt_y};
   assign w_in_x   = (w_cx >= w_tx) && (w_cx < (w_tx + C_BALL));
   assign w_in_y   = (w_cy >= w_ty) && (w_cy < (w_ty + C_BALL));
   assign w_in_box = w_in_x && w_in_y;

   // The tick that would bring the ms counter up to the timeout ends the round.
   assign w_ms_last  = (r_state == S_SHOW) && bus.tick_ms &&
                       (({1'b0, r_ms} + 17'd1) >= C_TIMEOUT);
   // The tick that completes the blank period ends the gap.
   assign w_gap_last = (r_state == S_GAP) && bus.tick_ms &&
                       (({1'b0, r_gap} + 17'd1) >= C_GAP);
   assign w_ms_sat   = (r_ms > 16'd4095) ? 12'hFFF : r_ms[11:0];

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode; a click in SHOW takes priority over a same-cycle timeout
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (bus.start) w_state_nxt = S_REQ;
         S_REQ:  w_state_nxt = S_LOAD;
         S_LOAD: w_state_nxt = S_SHOW;
         S_SHOW: if (bus.click || w_ms_last) w_state_nxt = S_GAP;
         S_GAP: begin
            if (w_gap_last) begin
               // round_no already counts the round that just finished
               w_state_nxt = (r_round < C_ROUNDS) ? S_REQ : S_DONE;
            end
         end
         S_DONE: if (bus.start) w_state_nxt = S_REQ;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output and datapath next values, registered below
   always_comb begin
      w_new_ball = (w_state_nxt == S_REQ);
      w_visible  = (w_state_nxt == S_SHOW);
      w_done     = (w_state_nxt == S_DONE);
      w_hit      = 1'b0;
      w_miss     = 1'b0;
      w_score    = r_score;
      w_misses   = r_misses;
      w_react    = r_react;
      w_round    = r_round;
      w_tgt_x    = r_tgt_x;
      w_tgt_y    = r_tgt_y;
      w_ms       = r_ms;
      w_gap      = r_gap;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               w_score  = 8'd0;
               w_misses = 8'd0;
               w_round  = 8'd0;
               w_react  = 12'd0;
            end
         end
         S_LOAD: begin
            // Generator answers on the cycle after the new_ball request.
            w_tgt_x = bus.ball_x;
            w_tgt_y = bus.ball_y;
            w_ms    = 16'd0;
         end
         S_SHOW: begin
            if (bus.click) begin
               if (w_in_box) begin
                  w_hit   = 1'b1;
                  w_score = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
                  w_react = w_ms_sat;
               end else begin
                  w_miss   = 1'b1;
                  w_misses = (r_misses == 8'hFF) ? r_misses : r_misses + 8'd1;
               end
            end else if (w_ms_last) begin
               w_miss   = 1'b1;
               w_misses = (r_misses == 8'hFF) ? r_misses : r_misses + 8'd1;
            end else if (bus.tick_ms && (r_ms != 16'hFFFF)) begin
               w_ms = r_ms + 16'd1;
            end
            if (w_state_nxt == S_GAP) begin
               w_round = (r_round == 8'hFF) ? r_round : r_round + 8'd1;
               w_gap   = 16'd0;
            end
         end
         S_GAP: begin
            if (bus.tick_ms && (r_gap != 16'hFFFF)) begin
               w_gap = r_gap + 16'd1;
            end
         end
         default: ;
      endcase
   end

   // Output and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ms       <= 16'd0;
         r_gap      <= 16'd0;
         r_new_ball <= 1'b0;
         r_visible  <= 1'b0;
         r_hit      <= 1'b0;
         r_miss     <= 1'b0;
         r_done     <= 1'b0;
         r_score    <= 8'd0;
         r_misses   <= 8'd0;
         r_react    <= 12'd0;
         r_round    <= 8'd0;
         r_tgt_x    <= 10'd0;
         r_tgt_y    <= 10'd0;
      end else begin
         r_ms       <= w_ms;
         r_gap      <= w_gap;
         r_new_ball <= w_new_ball;
         r_visible  <= w_visible;
         r_hit      <= w_hit;
         r_miss     <= w_miss;
         r_done     <= w_done;
         r_score    <= w_score;
         r_misses   <= w_misses;
         r_react    <= w_react;
         r_round    <= w_round;
         r_tgt_x    <= w_tgt_x;
         r_tgt_y    <= w_tgt_y;
      end
   end

   assign bus.new_ball     = r_new_ball;
   assign bus.ball_visible = r_visible;
   assign bus.hit          = r_hit;
   assign bus.miss         = r_miss;
   assign bus.done         = r_done;
   assign bus.score        = r_score;
   assign bus.misses       = r_misses;
   assign bus.react_ms     = r_react;
   assign bus.round_no     = r_round;
   assign bus.tgt_x        = r_tgt_x;
   assign bus.tgt_y        = r_tgt_y;
   assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_target_ctrl.sv
// Bench for the reaction-game controller: one task per scenario, results
// predicted into a queue at click/tick time and popped when hit/miss appears.
module tb_target_ctrl;
   localparam int BALL = 48;
   localparam int TMO  = 1500;
   localparam int GAP  = 500;
   localparam int RND  = 20;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   target_ctrl_if bus();

   target_ctrl #(
      .BALL_SIZE  (BALL),
      .TIMEOUT_MS (TMO),
      .GAP_MS     (GAP),
      .ROUNDS     (RND)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // {hit, miss, score, misses, react_ms}
   logic [29:0] exp_q[$];
   int exp_score  = 0;
   int exp_misses = 0;
   int exp_react  = 0;
   int exp_round  = 0;

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         bus.tick_ms = 1'b1;
         step();
      end
      bus.tick_ms = 1'b0;
   endtask

   task automatic wait_result(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (bus.hit || bus.miss) begin
            ok = 1'b1;
            return;
         end
         step();
      end
   endtask

   task automatic enter_show(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (bus.new_ball) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      step();
      step();
   endtask

   function automatic bit in_box(input int x, input int y, input int tx, input int ty);
      return (x >= tx) && (x < tx + BALL) && (y >= ty) && (y < ty + BALL);
   endfunction

   task automatic play_click(input int x, input int y, input int tx, input int ty,
                             input int wait_ticks);
      logic [29:0] e;
      tick_n(wait_ticks);
      bus.cursor_x = 10'(x);
      bus.cursor_y = 10'(y);
      if (in_box(x, y, tx, ty)) begin
         if (exp_score < 255) exp_score++;
         exp_react = (wait_ticks > 4095) ? 4095 : wait_ticks;
         e[29:28] = 2'b10;
      end else begin
         if (exp_misses < 255) exp_misses++;
         e[29:28] = 2'b01;
      end
      exp_round++;
      e[27:0] = {8'(exp_score), 8'(exp_misses), 12'(exp_react)};
      exp_q.push_back(e);
      bus.click = 1'b1;
      step();
      bus.click = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [63:0] got;
      rst = 1'b1;
      step();
      step();
      got = {bus.new_ball, bus.ball_visible, bus.hit, bus.miss, bus.done, bus.score,
             bus.misses, bus.react_ms, bus.round_no, bus.tgt_x, bus.tgt_y};
      n_checks++;
      if (got !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %0h expected 0", got);
      end
      n_checks++;
      if (bus.dbg_state !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_state: got %0d expected 0", bus.dbg_state);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_first_hit();
      bit ok;
      logic [29:0] e;
      logic [29:0] got;
      bus.ball_x = 10'd100;
      bus.ball_y = 10'd200;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      n_checks++;
      if (bus.new_ball !== 1'b1) begin
         n_fail++;
         $display("FAIL new_ball_after_start: got %b expected 1", bus.new_ball);
      end
      step();
      n_checks++;
      if (bus.new_ball !== 1'b0) begin
         n_fail++;
         $display("FAIL new_ball_one_cycle: got %b expected 0", bus.new_ball);
      end
      step();
      n_checks++;
      if ({bus.ball_visible, bus.tgt_x, bus.tgt_y} !== {1'b1, 10'd100, 10'd200}) begin
         n_fail++;
         $display("FAIL show_latch: got vis=%b tgt=(%0d,%0d) expected vis=1 tgt=(100,200)",
                  bus.ball_visible, bus.tgt_x, bus.tgt_y);
      end
      // start while the target is shown has no effect
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      n_checks++;
      if ({bus.dbg_state, bus.new_ball} !== {3'd3, 1'b0}) begin
         n_fail++;
         $display("FAIL start_ignored: got state=%0d new_ball=%b expected state=3 new_ball=0",
                  bus.dbg_state, bus.new_ball);
      end
      play_click(120, 220, 100, 200, 250);
      wait_result(ok);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL first_hit_seen: got none expected hit/miss");
      end else begin
         got = {bus.hit, bus.miss, bus.score, bus.misses, bus.react_ms};
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL first_hit_result: got %0h expected %0h", got, e);
         end
      end
      step();
      n_checks++;
      if ({bus.hit, bus.ball_visible, bus.round_no} !== {1'b0, 1'b0, 8'd1}) begin
         n_fail++;
         $display("FAIL after_hit: got hit=%b vis=%b round=%0d expected 0 0 1",
                  bus.hit, bus.ball_visible, bus.round_no);
      end
      // click during the gap is ignored
      bus.click = 1'b1;
      step();
      bus.click = 1'b0;
      step();
      n_checks++;
      if ({bus.hit, bus.miss, bus.misses} !== {1'b0, 1'b0, 8'd0}) begin
         n_fail++;
         $display("FAIL gap_click_ignored: got hit=%b miss=%b misses=%0d expected 0 0 0",
                  bus.hit, bus.miss, bus.misses);
      end
   endtask

   task automatic test_edges();
      int tx[6] = '{100, 100, 100, 100, 1000, 1000};
      int ty[6] = '{200, 200, 200, 200, 1000, 1000};
      int cx[6] = '{148, 147, 100, 99, 1023, 5};
      int cy[6] = '{200, 247, 248, 220, 1023, 5};
      bit ok;
      logic [29:0] e;
      logic [29:0] got;
      for (int k = 0; k < 6; k++) begin
         bus.ball_x = 10'(tx[k]);
         bus.ball_y = 10'(ty[k]);
         tick_n(GAP);
         enter_show(ok);
         n_checks++;
         if (!ok) begin
            n_fail++;
            $display("FAIL edge%0d_new_ball: got none expected pulse", k);
         end
         n_checks++;
         if ({bus.tgt_x, bus.tgt_y} !== {10'(tx[k]), 10'(ty[k])}) begin
            n_fail++;
            $display("FAIL edge%0d_tgt: got (%0d,%0d) expected (%0d,%0d)",
                     k, bus.tgt_x, bus.tgt_y, tx[k], ty[k]);
         end
         play_click(cx[k], cy[k], tx[k], ty[k], int'($urandom_range(0, 40)));
         wait_result(ok);
         e = exp_q.pop_front();
         n_checks++;
         if (!ok) begin
            n_fail++;
            $display("FAIL edge%0d_seen: got none expected hit/miss", k);
         end else begin
            got = {bus.hit, bus.miss, bus.score, bus.misses, bus.react_ms};
            n_checks++;
            if (got !== e) begin
               n_fail++;
               $display("FAIL edge%0d_result: got %0h expected %0h", k, got, e);
            end
         end
      end
   endtask

   task automatic test_timeout();
      bit ok;
      logic [29:0] e;
      logic [29:0] got;
      tick_n(GAP);
      enter_show(ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL timeout_new_ball: got none expected pulse");
      end
      tick_n(TMO - 1);
      n_checks++;
      if ({bus.miss, bus.ball_visible} !== 2'b01) begin
         n_fail++;
         $display("FAIL before_timeout: got miss=%b vis=%b expected 0 1", bus.miss, bus.ball_visible);
      end
      if (exp_misses < 255) exp_misses++;
      exp_round++;
      exp_q.push_back({2'b01, 8'(exp_score), 8'(exp_misses), 12'(exp_react)});
      tick_n(1);
      wait_result(ok);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL timeout_seen: got none expected miss");
      end else begin
         got = {bus.hit, bus.miss, bus.score, bus.misses, bus.react_ms};
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL timeout_result: got %0h expected %0h", got, e);
         end
      end
      n_checks++;
      if (bus.ball_visible !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_visible: got %b expected 0", bus.ball_visible);
      end
      tick_n(GAP - 1);
      n_checks++;
      if (bus.new_ball !== 1'b0) begin
         n_fail++;
         $display("FAIL gap_early_new_ball: got %b expected 0", bus.new_ball);
      end
      tick_n(1);
      n_checks++;
      if (bus.new_ball !== 1'b1) begin
         n_fail++;
         $display("FAIL gap_end_new_ball: got %b expected 1", bus.new_ball);
      end
   endtask

   task automatic test_coincident();
      bit ok;
      bit saw_miss;
      logic [29:0] e;
      logic [29:0] got;
      enter_show(ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL coinc_new_ball: got none expected pulse");
      end
      tick_n(TMO - 1);
      bus.cursor_x = 10'(bus.tgt_x + 10'd10);
      bus.cursor_y = 10'(bus.tgt_y + 10'd10);
      if (exp_score < 255) exp_score++;
      exp_round++;
      exp_q.push_back({2'b10, 8'(exp_score), 8'(exp_misses), 12'd0});
      bus.tick_ms = 1'b1;
      bus.click   = 1'b1;
      step();
      bus.tick_ms = 1'b0;
      bus.click   = 1'b0;
      wait_result(ok);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL coinc_seen: got none expected hit");
      end else begin
         got = {bus.hit, bus.miss, bus.score, bus.misses, bus.react_ms};
         n_checks++;
         if (got[29:12] !== e[29:12]) begin
            n_fail++;
            $display("FAIL coinc_result: got %0h expected %0h", got[29:12], e[29:12]);
         end
      end
      saw_miss = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (bus.miss || bus.hit) saw_miss = 1'b1;
      end
      n_checks++;
      if (saw_miss !== 1'b0) begin
         n_fail++;
         $display("FAIL coinc_single_pulse: got extra pulse expected none");
      end
   endtask

   task automatic test_done();
      bit ok;
      bit saw_nb;
      logic [29:0] e;
      logic [29:0] got;
      bus.ball_x = 10'd1000;
      bus.ball_y = 10'd1000;
      while (exp_round < RND) begin
         tick_n(GAP);
         enter_show(ok);
         n_checks++;
         if (!ok) begin
            n_fail++;
            $display("FAIL round%0d_new_ball: got none expected pulse", exp_round + 1);
         end
         play_click(1005, 1005, 1000, 1000, int'($urandom_range(1, 60)));
         wait_result(ok);
         e = exp_q.pop_front();
         n_checks++;
         if (!ok) begin
            n_fail++;
            $display("FAIL round%0d_seen: got none expected hit", exp_round);
         end else begin
            got = {bus.hit, bus.miss, bus.score, bus.misses, bus.react_ms};
            n_checks++;
            if (got !== e) begin
               n_fail++;
               $display("FAIL round%0d_result: got %0h expected %0h", exp_round, got, e);
            end
         end
      end
      tick_n(GAP);
      n_checks++;
      if ({bus.done, bus.round_no, bus.score, bus.misses, bus.new_ball} !==
          {1'b1, 8'(RND), 8'(exp_score), 8'(exp_misses), 1'b0}) begin
         n_fail++;
         $display("FAIL game_done: got done=%b round=%0d score=%0d misses=%0d nb=%b expected 1 %0d %0d %0d 0",
                  bus.done, bus.round_no, bus.score, bus.misses, bus.new_ball,
                  RND, exp_score, exp_misses);
      end
      saw_nb = 1'b0;
      for (int i = 0; i < 30; i++) begin
         bus.tick_ms = 1'(i % 2);
         step();
         if (bus.new_ball) saw_nb = 1'b1;
      end
      bus.tick_ms = 1'b0;
      n_checks++;
      if ({saw_nb, bus.done} !== 2'b01) begin
         n_fail++;
         $display("FAIL done_hold: got new_ball_seen=%b done=%b expected 0 1", saw_nb, bus.done);
      end
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      exp_score = 0;
      exp_misses = 0;
      exp_react = 0;
      exp_round = 0;
      n_checks++;
      if ({bus.new_ball, bus.done, bus.score, bus.misses, bus.round_no, bus.react_ms} !==
          {1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 12'd0}) begin
         n_fail++;
         $display("FAIL restart: got nb=%b done=%b score=%0d misses=%0d round=%0d react=%0d expected 1 0 0 0 0 0",
                  bus.new_ball, bus.done, bus.score, bus.misses, bus.round_no, bus.react_ms);
      end
   endtask

   task automatic test_reset_mid_round();
      bit ok;
      bit saw;
      logic [29:0] e;
      logic [29:0] got;
      logic [63:0] outs;
      enter_show(ok);
      play_click(1020, 1000, 1000, 1000, 33);
      wait_result(ok);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL pre_reset_seen: got none expected hit");
      end else begin
         got = {bus.hit, bus.miss, bus.score, bus.misses, bus.react_ms};
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL pre_reset_result: got %0h expected %0h", got, e);
         end
      end
      tick_n(GAP);
      enter_show(ok);
      tick_n(7);
      rst = 1'b1;
      step();
      rst = 1'b0;
      outs = {bus.new_ball, bus.ball_visible, bus.hit, bus.miss, bus.done, bus.score,
              bus.misses, bus.react_ms, bus.round_no, bus.tgt_x, bus.tgt_y};
      n_checks++;
      if ({bus.dbg_state, outs} !== {3'd0, 64'd0}) begin
         n_fail++;
         $display("FAIL mid_reset: got state=%0d outs=%0h expected 0 0", bus.dbg_state, outs);
      end
      saw = 1'b0;
      bus.cursor_x = 10'd10;
      bus.cursor_y = 10'd10;
      for (int i = 0; i < 6; i++) begin
         bus.click   = 1'(i % 2);
         bus.tick_ms = 1'b1;
         step();
         if (bus.hit || bus.miss || bus.new_ball || bus.ball_visible) saw = 1'b1;
      end
      bus.click   = 1'b0;
      bus.tick_ms = 1'b0;
      n_checks++;
      if ({saw, bus.dbg_state} !== {1'b0, 3'd0}) begin
         n_fail++;
         $display("FAIL idle_ignores_click: got activity=%b state=%0d expected 0 0", saw, bus.dbg_state);
      end
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      n_checks++;
      if (bus.new_ball !== 1'b1) begin
         n_fail++;
         $display("FAIL start_after_reset: got %b expected 1", bus.new_ball);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      bus.start    = 1'b0;
      bus.tick_ms  = 1'b0;
      bus.click    = 1'b0;
      bus.cursor_x = 10'd0;
      bus.cursor_y = 10'd0;
      bus.ball_x   = 10'd0;
      bus.ball_y   = 10'd0;
      test_reset();
      test_first_hit();
      test_edges();
      test_timeout();
      test_coincident();
      test_done();
      test_reset_mid_round();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/target_ctrl.md
TARGET_CTRL -- requirements
Module: target_ctrl

Interface
REQ-001 Parameters SHALL be: BALL_SIZE, default 48, ball square edge in pixels; TIMEOUT_MS, default 1500, max reaction window; GAP_MS, default 500, blank time between rounds; ROUNDS, default 20, rounds per game.
REQ-002 clk  in  1  system clock.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  one-cycle pulse, begins a game.
REQ-005 tick_ms  in  1  one-cycle pulse every millisecond.
REQ-006 click  in  1  one-cycle pulse, player click.
REQ-007 cursor_x, cursor_y  in  10 each  cursor pixel position.
REQ-008 ball_x, ball_y  in  10 each  top-left of target from the position generator.
REQ-009 new_ball  out  1  one-cycle request for a new target position.
REQ-010 ball_visible  out  1  high while the target is shown.
REQ-011 tgt_x, tgt_y  out  10 each  latched target position.
REQ-012 hit, miss  out  1 each  one-cycle round-result pulses.
REQ-013 score, misses  out  8 each  game counters.
REQ-014 react_ms  out  12  reaction time of the last hit.
REQ-015 round_no  out  8  rounds completed.
REQ-016 done  out  1  high when game complete.

Function
REQ-017 FSM states SHALL be IDLE, REQ, LOAD, SHOW, GAP, DONE.
REQ-018 IDLE: on start -> REQ; clear score, misses, round_no, react_ms.
REQ-019 REQ: assert new_ball for exactly one cycle -> LOAD.
REQ-020 LOAD: on the cycle after new_ball, latch ball_x/ball_y into tgt_x/tgt_y, clear ms counter -> SHOW.
REQ-021 SHOW: ball_visible = 1; ms counter increments on each tick_ms.
REQ-022 Hit test SHALL use 11-bit unsigned compare: tgt_x <= cursor_x < tgt_x+BALL_SIZE and tgt_y <= cursor_y < tgt_y+BALL_SIZE; no wrap at 1023.
REQ-023 SHOW + click inside box -> pulse hit, score+1 (saturate 255), react_ms = ms counter (saturate 4095), -> GAP.
REQ-024 SHOW + click outside box -> pulse miss, misses+1 (saturate 255), react_ms unchanged, -> GAP.
REQ-025 SHOW + ms counter reaching TIMEOUT_MS with no click -> pulse miss, misses+1, -> GAP.
REQ-026 click and timeout in the same cycle: click evaluation SHALL win; exactly one of hit/miss pulses.
REQ-027 GAP: ball_visible = 0; entry increments round_no; after GAP_MS ticks -> REQ if round_no < ROUNDS, else DONE.
REQ-028 click outside SHOW SHALL be ignored; start outside IDLE/DONE SHALL be ignored.
REQ-029 DONE: done = 1, counters held; start -> REQ with counters cleared as in REQ-018.
REQ-030 hit/miss/new_ball SHALL never assert in the same cycle as each other.
REQ-031 Outputs SHALL be registered; result pulses appear one cycle after the deciding click/tick.

Reset
REQ-032 rst SHALL, at any state including mid-round, force IDLE next cycle with all outputs 0: new_ball, ball_visible, hit, miss, done, score, misses, react_ms, round_no, tgt_x, tgt_y, ms counter, gap counter.

Verification
REQ-033 start, ball_x=100, ball_y=200, click after 250 ticks at (120,220) -> hit pulse, score=1, react_ms=250, tgt=(100,200).
REQ-034 Click at (148,200) with tgt=(100,200) -> miss (right edge exclusive); at (147,247) -> hit.
REQ-035 No click for 1500 ticks -> miss at TIMEOUT, misses=1, ball_visible drops, new_ball again after 500 gap ticks.
REQ-036 Click coincident with the 1500th tick inside box -> single hit pulse, no miss.
REQ-037 20 rounds completed -> done=1, round_no=20, no further new_ball; start -> counters 0, new_ball pulse.
REQ-038 rst asserted during SHOW -> next cycle IDLE, ball_visible=0, score=0; clicks ignored until start.
